// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file, load-use hazard detection,
// branch resolution in decode and a registered ID/EX boundary.
module id_stage_pipe #(
   parameter int DATA_W    = 16,
   parameter int NUM_REGS  = 16,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [15:0]       instruction,
   input  logic [15:0]       pc,
   input  logic [2:0]        flag,
   input  logic              ex_hold,
   input  logic              wb_we,
   input  logic [3:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall_id,
   output logic              branch_taken,
   output logic [15:0]       branch_target,
   output logic              ex_valid,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_memtoreg,
   output logic              ex_alusrc,
   output logic              ex_pcs,
   output logic              ex_hlt,
   output logic [3:0]        ex_aluop,
   output logic [3:0]        ex_rd,
   output logic [3:0]        ex_rs,
   output logic [3:0]        ex_rt,
   output logic [DATA_W-1:0] ex_data1,
   output logic [DATA_W-1:0] ex_data2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [15:0]       ex_pc_next
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [4:0] NR = 5'(NUM_REGS);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
      logic              alusrc;
      logic              pcs;
      logic              hlt;
      logic [3:0]        aluop;
      logic [3:0]        rd;
      logic [3:0]        rs;
      logic [3:0]        rt;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
      logic [DATA_W-1:0] imm;
      logic [15:0]       pc_next;
   } id_ex_t;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   id_ex_t            ex_q, ex_d, dec;
   logic              use_rs, use_rt, lu_hazard, cond_met, wr_ok;
   logic [3:0]        op;
   logic [15:0]       pc_plus2;

   assign op       = instruction[15:12];
   assign pc_plus2 = pc + 16'd2;
   // Dropped writes: out-of-range addresses and, optionally, R0.
   assign wr_ok    = wb_we && ({1'b0, wb_addr} < NR) && !(ZERO_REG != 0 && wb_addr == 4'd0);

   // Combinational register read with optional same-cycle write-back bypass.
   function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] a);
      if (({1'b0, a} >= NR) || (ZERO_REG != 0 && a == 4'd0)) return '0;
      if (BYPASS_EN != 0 && wr_ok && wb_addr == a) return wb_data;
      return regs_q[a[AW-1:0]];
   endfunction

   // Next register-file contents from the write-back port.
   always_comb begin
      regs_d = regs_q;
      if (wr_ok) regs_d[wb_addr[AW-1:0]] = wb_data;
   end

   // Register-file storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Field decode, control generation, immediate extension and operand read.
   always_comb begin
      dec         = '0;
      use_rs      = 1'b0;
      use_rt      = 1'b0;
      dec.valid   = 1'b1;
      dec.aluop   = op;
      dec.pc_next = pc_plus2;
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3: begin
            dec.rd = instruction[11:8]; dec.rs = instruction[7:4]; dec.rt = instruction[3:0];
            dec.regwrite = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
         end
         4'h4, 4'h5, 4'h6: begin
            dec.rd = instruction[11:8]; dec.rs = instruction[7:4];
            dec.imm = {{(DATA_W-4){1'b0}}, instruction[3:0]};
            dec.alusrc = 1'b1; dec.regwrite = 1'b1; use_rs = 1'b1;
         end
         4'h8: begin
            dec.rd = instruction[11:8]; dec.rs = instruction[7:4];
            dec.imm = {{(DATA_W-5){instruction[3]}}, instruction[3:0], 1'b0};
            dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
            use_rs = 1'b1;
         end
         4'h9: begin
            dec.rt = instruction[11:8]; dec.rs = instruction[7:4];
            dec.imm = {{(DATA_W-5){instruction[3]}}, instruction[3:0], 1'b0};
            dec.memwrite = 1'b1; dec.alusrc = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
         end
         4'hA, 4'hB: begin
            // LLB/LHB merge into the existing rd value, so rd is also a source.
            dec.rd = instruction[11:8]; dec.rt = instruction[11:8];
            dec.imm = {{(DATA_W-8){1'b0}}, instruction[7:0]};
            dec.regwrite = 1'b1; dec.alusrc = 1'b1; use_rt = 1'b1;
         end
         4'hC: dec.imm = {{(DATA_W-10){instruction[8]}}, instruction[8:0], 1'b0};
         4'hD: begin dec.rs = instruction[7:4]; use_rs = 1'b1; end
         4'hE: begin dec.rd = instruction[11:8]; dec.regwrite = 1'b1; dec.pcs = 1'b1; end
         4'hF: dec.hlt = 1'b1;
         default: ;
      endcase
      dec.data1 = rf_read(dec.rs);
      dec.data2 = rf_read(dec.rt);
   end

   // Load-use hazard against whatever ID/EX currently holds (held or not).
   always_comb begin
      lu_hazard = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != 4'd0) &&
                  ((use_rs && ex_q.rd == dec.rs) || (use_rt && ex_q.rd == dec.rt));
      stall_id  = id_valid && (lu_hazard || ex_hold);
   end

   // Branch condition over {Z,V,N} and fetch redirect.
   always_comb begin
      case (instruction[11:9])
         3'b000:  cond_met = !flag[2];
         3'b001:  cond_met = flag[2];
         3'b010:  cond_met = !flag[2] && !flag[0];
         3'b011:  cond_met = flag[0];
         3'b100:  cond_met = flag[2] || !flag[0];
         3'b101:  cond_met = flag[2] || flag[0];
         3'b110:  cond_met = flag[1];
         default: cond_met = 1'b1;
      endcase
      branch_taken  = id_valid && !stall_id && (op == 4'hC || op == 4'hD) && cond_met;
      branch_target = pc_plus2;
      if (branch_taken) branch_target = (op == 4'hC) ? pc_plus2 + dec.imm[15:0] : dec.data1[15:0];
   end

   // ID/EX next state: hold, capture the decode, or insert a bubble.
   always_comb begin
      if (ex_hold)                     ex_d = ex_q;
      else if (id_valid && !lu_hazard) ex_d = dec;
      else                             ex_d = '0;
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ex_q <= '0;
      else      ex_q <= ex_d;
   end

   assign ex_valid    = ex_q.valid;
   assign ex_regwrite = ex_q.regwrite;
   assign ex_memread  = ex_q.memread;
   assign ex_memwrite = ex_q.memwrite;
   assign ex_memtoreg = ex_q.memtoreg;
   assign ex_alusrc   = ex_q.alusrc;
   assign ex_pcs      = ex_q.pcs;
   assign ex_hlt      = ex_q.hlt;
   assign ex_aluop    = ex_q.aluop;
   assign ex_rd       = ex_q.rd;
   assign ex_rs       = ex_q.rs;
   assign ex_rt       = ex_q.rt;
   assign ex_data1    = ex_q.data1;
   assign ex_data2    = ex_q.data2;
   assign ex_imm      = ex_q.imm;
   assign ex_pc_next  = ex_q.pc_next;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed tests of three id_stage_pipe variants sharing one
// stimulus stream: [0] defaults, [1] BYPASS_EN=0, [2] NUM_REGS=8.
module tb_id_stage_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0, ex_hold = 1'b0, wb_we = 1'b0;
   logic [15:0] instruction = '0, pc = '0, wb_data = '0;
   logic [2:0]  flag = '0;
   logic [3:0]  wb_addr = '0;

   logic        stall_w [3], taken_w [3], valid_w [3], regwr_w [3], memrd_w [3];
   logic        memwr_w [3], memtoreg_w [3], alusrc_w [3], pcs_w [3], hlt_w [3];
   logic [15:0] target_w [3], data1_w [3], data2_w [3], imm_w [3], pcn_w [3];
   logic [3:0]  aluop_w [3], rd_w [3], rs_w [3], rt_w [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      id_stage_pipe #(
         .DATA_W(16), .NUM_REGS((g == 2) ? 8 : 16), .ZERO_REG(1), .BYPASS_EN((g == 1) ? 0 : 1)
      ) u_dut (
         .clk(clk), .rst(rst), .id_valid(id_valid), .instruction(instruction), .pc(pc),
         .flag(flag), .ex_hold(ex_hold), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
         .stall_id(stall_w[g]), .branch_taken(taken_w[g]), .branch_target(target_w[g]),
         .ex_valid(valid_w[g]), .ex_regwrite(regwr_w[g]), .ex_memread(memrd_w[g]),
         .ex_memwrite(memwr_w[g]), .ex_memtoreg(memtoreg_w[g]), .ex_alusrc(alusrc_w[g]),
         .ex_pcs(pcs_w[g]), .ex_hlt(hlt_w[g]), .ex_aluop(aluop_w[g]), .ex_rd(rd_w[g]),
         .ex_rs(rs_w[g]), .ex_rt(rt_w[g]), .ex_data1(data1_w[g]), .ex_data2(data2_w[g]),
         .ex_imm(imm_w[g]), .ex_pc_next(pcn_w[g])
      );
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
      id_valid = 1'b0; wb_we = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_we = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++; if (valid_w[0] !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", valid_w[0]); end
      checks++; if (stall_w[0] !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall_w[0]); end
      rst = 1'b1;
      wb_write(4'd5, 16'h5555);
      id_valid = 1'b1; instruction = 16'h0150; pc = 16'h0000;
      step();
      checks++; if (data1_w[0] !== 16'h5555) begin errors++; $display("FAIL pre_rst_data1 got=%h exp=5555", data1_w[0]); end
      checks++; if (valid_w[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%0h exp=1", valid_w[0]); end
      rst = 1'b0; #1;
      checks++; if (valid_w[0] !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%0h exp=0", valid_w[0]); end
      checks++; if ({regwr_w[0], rd_w[0], rs_w[0], data1_w[0], pcn_w[0]} !== '0) begin
         errors++; $display("FAIL async_rst_fields rd=%h rs=%h d1=%h pcn=%h exp=0", rd_w[0], rs_w[0], data1_w[0], pcn_w[0]); end
      checks++; if (stall_w[0] !== 1'b0) begin errors++; $display("FAIL async_rst_stall got=%0h exp=0", stall_w[0]); end
      #2; rst = 1'b1;
      step();
      checks++; if (data1_w[0] !== 16'h0000) begin errors++; $display("FAIL post_rst_r5 got=%h exp=0000", data1_w[0]); end
   endtask

   task automatic test_bypass();
      wb_write(4'd3, 16'h1111);
      id_valid = 1'b1; instruction = 16'h0134; wb_we = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
      step();
      wb_we = 1'b0;
      checks++; if (data1_w[0] !== 16'h1234) begin errors++; $display("FAIL bypass_on got=%h exp=1234", data1_w[0]); end
      checks++; if (data1_w[1] !== 16'h1111) begin errors++; $display("FAIL bypass_off got=%h exp=1111", data1_w[1]); end
      checks++; if ({rd_w[0], rs_w[0], rt_w[0], regwr_w[0]} !== {4'd1, 4'd3, 4'd4, 1'b1}) begin
         errors++; $display("FAIL add_fields rd=%h rs=%h rt=%h rw=%0h exp=1 3 4 1", rd_w[0], rs_w[0], rt_w[0], regwr_w[0]); end
      instruction = 16'h0100; wb_we = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
      step();
      wb_we = 1'b0;
      checks++; if (data1_w[0] !== 16'h0000) begin errors++; $display("FAIL r0_bypass got=%h exp=0000", data1_w[0]); end
      step();
      checks++; if ({data1_w[0], data2_w[0]} !== 32'h0) begin errors++; $display("FAIL r0_read got=%h/%h exp=0", data1_w[0], data2_w[0]); end
   endtask

   task automatic test_load_use();
      instruction = 16'h821F;
      step();
      checks++; if ({valid_w[0], memrd_w[0], memtoreg_w[0], rd_w[0]} !== {3'b111, 4'd2}) begin
         errors++; $display("FAIL lw_ctrl v=%0h mr=%0h mtr=%0h rd=%h exp=1 1 1 2", valid_w[0], memrd_w[0], memtoreg_w[0], rd_w[0]); end
      checks++; if (imm_w[0] !== 16'hFFFE) begin errors++; $display("FAIL lw_imm got=%h exp=fffe", imm_w[0]); end
      instruction = 16'h0324; #1;
      checks++; if (stall_w[0] !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0h exp=1", stall_w[0]); end
      step();
      checks++; if ({valid_w[0], memrd_w[0], regwr_w[0]} !== 3'b000) begin
         errors++; $display("FAIL lu_bubble v=%0h mr=%0h rw=%0h exp=0", valid_w[0], memrd_w[0], regwr_w[0]); end
      checks++; if (stall_w[0] !== 1'b0) begin errors++; $display("FAIL lu_release got=%0h exp=0", stall_w[0]); end
      step();
      checks++; if ({valid_w[0], rd_w[0], rs_w[0]} !== {1'b1, 4'd3, 4'd2}) begin
         errors++; $display("FAIL lu_add v=%0h rd=%h rs=%h exp=1 3 2", valid_w[0], rd_w[0], rs_w[0]); end
      instruction = 16'h8010;
      step();
      instruction = 16'h0304; #1;
      checks++; if (stall_w[0] !== 1'b0) begin errors++; $display("FAIL lu_r0_nostall got=%0h exp=0", stall_w[0]); end
      step();
   endtask

   task automatic test_branch();
      pc = 16'h0010; instruction = 16'hC203; flag = 3'b100; #1;
      checks++; if ({taken_w[0], target_w[0]} !== {1'b1, 16'h0018}) begin
         errors++; $display("FAIL b_taken t=%0h tgt=%h exp=1 0018", taken_w[0], target_w[0]); end
      flag = 3'b000; #1;
      checks++; if ({taken_w[0], target_w[0]} !== {1'b0, 16'h0012}) begin
         errors++; $display("FAIL b_not_taken t=%0h tgt=%h exp=0 0012", taken_w[0], target_w[0]); end
      flag = 3'b100;
      step();
      checks++; if ({valid_w[0], regwr_w[0], aluop_w[0], imm_w[0]} !== {2'b10, 4'hC, 16'h0006}) begin
         errors++; $display("FAIL b_in_ex v=%0h rw=%0h op=%h imm=%h exp=1 0 c 0006", valid_w[0], regwr_w[0], aluop_w[0], imm_w[0]); end
      instruction = 16'hC3FF; #1;
      checks++; if ({taken_w[0], target_w[0]} !== {1'b1, 16'h0010}) begin
         errors++; $display("FAIL b_neg t=%0h tgt=%h exp=1 0010", taken_w[0], target_w[0]); end
      instruction = 16'hC403; flag = 3'b001; #1;
      checks++; if (taken_w[0] !== 1'b0) begin errors++; $display("FAIL b_c010_n got=%0h exp=0", taken_w[0]); end
      flag = 3'b000; #1;
      checks++; if ({taken_w[0], target_w[0]} !== {1'b1, 16'h0018}) begin
         errors++; $display("FAIL b_c010 t=%0h tgt=%h exp=1 0018", taken_w[0], target_w[0]); end
      wb_write(4'd7, 16'h0ABC);
      id_valid = 1'b1; instruction = 16'hDE70; #1;
      checks++; if ({taken_w[0], target_w[0]} !== {1'b1, 16'h0ABC}) begin
         errors++; $display("FAIL br_taken t=%0h tgt=%h exp=1 0abc", taken_w[0], target_w[0]); end
      instruction = 16'h8710;
      step();
      instruction = 16'hDE70; #1;
      checks++; if ({stall_w[0], taken_w[0], target_w[0]} !== {2'b10, 16'h0012}) begin
         errors++; $display("FAIL br_lu_stall s=%0h t=%0h tgt=%h exp=1 0 0012", stall_w[0], taken_w[0], target_w[0]); end
      step();
      checks++; if ({taken_w[0], target_w[0]} !== {1'b1, 16'h0ABC}) begin
         errors++; $display("FAIL br_after_stall t=%0h tgt=%h exp=1 0abc", taken_w[0], target_w[0]); end
      step();
      checks++; if ({valid_w[0], regwr_w[0], aluop_w[0]} !== {2'b10, 4'hD}) begin
         errors++; $display("FAIL br_in_ex v=%0h rw=%0h op=%h exp=1 0 d", valid_w[0], regwr_w[0], aluop_w[0]); end
   endtask

   task automatic test_hold();
      instruction = 16'h0134; ex_hold = 1'b1; #1;
      for (int c = 0; c < 2; c++) begin
         checks++; if (stall_w[0] !== 1'b1) begin errors++; $display("FAIL hold_stall%0d got=%0h exp=1", c, stall_w[0]); end
         step();
         checks++; if ({valid_w[0], aluop_w[0], rd_w[0]} !== {1'b1, 4'hD, 4'd0}) begin
            errors++; $display("FAIL hold_keep%0d v=%0h op=%h rd=%h exp=1 d 0", c, valid_w[0], aluop_w[0], rd_w[0]); end
      end
      ex_hold = 1'b0; #1;
      checks++; if (stall_w[0] !== 1'b0) begin errors++; $display("FAIL hold_release got=%0h exp=0", stall_w[0]); end
      step();
      checks++; if ({aluop_w[0], rd_w[0], data1_w[0]} !== {4'h0, 4'd1, 16'h1234}) begin
         errors++; $display("FAIL hold_capture op=%h rd=%h d1=%h exp=0 1 1234", aluop_w[0], rd_w[0], data1_w[0]); end
   endtask

   task automatic test_small_rf();
      wb_write(4'd9, 16'hBEEF);
      id_valid = 1'b1; instruction = 16'h0190;
      step();
      checks++; if (data1_w[2] !== 16'h0000) begin errors++; $display("FAIL n8_r9 got=%h exp=0000", data1_w[2]); end
      checks++; if (data1_w[0] !== 16'hBEEF) begin errors++; $display("FAIL n16_r9 got=%h exp=beef", data1_w[0]); end
      instruction = 16'hE600; pc = 16'h00FE;
      step();
      checks++; if ({pcn_w[2], pcs_w[2], regwr_w[2], rd_w[2]} !== {16'h0100, 2'b11, 4'd6}) begin
         errors++; $display("FAIL pcs pcn=%h pcs=%0h rw=%0h rd=%h exp=0100 1 1 6", pcn_w[2], pcs_w[2], regwr_w[2], rd_w[2]); end
      instruction = 16'hF000;
      step();
      checks++; if ({valid_w[0], hlt_w[0]} !== 2'b11) begin errors++; $display("FAIL hlt v=%0h h=%0h exp=1 1", valid_w[0], hlt_w[0]); end
      id_valid = 1'b0;
      step();
      checks++; if ({valid_w[0], hlt_w[0]} !== 2'b00) begin errors++; $display("FAIL idle_bubble v=%0h h=%0h exp=0 0", valid_w[0], hlt_w[0]); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_load_use();
      test_branch();
      test_hold();
      test_small_rf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
